// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory load/store front-end.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR,
        ST_RESP
    } state_e;

    // A request that must be rejected without touching the RAM.
    function automatic logic req_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            SZ_RSVD: bad = 1'b1;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// CPU-side request/response bus of the data-memory access unit.
interface dmem_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W+1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte/half lane extraction with extension for loads, lane merge for partial stores.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sign_ext,
    input  logic [31:0] rdword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data_c,
    output logic [31:0] merged_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel    = rdword[{addr_lo, 3'b000} +: 8];
        half_sel    = addr_lo[1] ? rdword[31:16] : rdword[15:0];
        load_data_c = '0;
        merged_c    = rdword;
        case (size)
            SZ_BYTE: begin
                load_data_c = {{24{sign_ext & byte_sel[7]}}, byte_sel};
                merged_c[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data_c = {{16{sign_ext & half_sel[15]}}, half_sel};
                if (addr_lo[1]) merged_c[31:16] = wdata[15:0];
                else            merged_c[15:0]  = wdata[15:0];
            end
            SZ_WORD: begin
                load_data_c = rdword;
                merged_c    = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store front-end for a 256x32 dual-port RAM: one request at a time,
// sub-word loads with extension, sub-word stores by read-modify-write.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_if.slave             bus,
    output logic              ram_ena,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dina,
    output logic [ADDR_W-1:0] ram_addrb,
    input  logic [DATA_W-1:0] ram_doutb
);

    localparam int unsigned BADDR_W = ADDR_W + 2;

    state_e state_q, state_nxt;

    logic               accept;
    logic               req_bad;
    logic               we_q;
    logic [1:0]         size_q;
    logic               sign_q;
    logic [BADDR_W-1:0] addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [31:0]        load_data;
    logic [31:0]        merged;

    assign accept  = bus.req_valid && bus.req_ready;
    assign req_bad = req_misaligned(bus.req_size, bus.req_addr[1:0]);

    dmem_lane_align u_lane_align (
        .size        (size_q),
        .addr_lo     (addr_q[1:0]),
        .sign_ext    (sign_q),
        .rdword      (ram_doutb),
        .wdata       (wdata_q),
        .load_data_c (load_data),
        .merged_c    (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_bad)                                  state_nxt = ST_RESP;
                    else if (bus.req_we && bus.req_size == SZ_WORD) state_nxt = ST_WR;
                    else                                          state_nxt = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: state_nxt = ST_RD_DATA;
            ST_RD_DATA: state_nxt = we_q ? ST_WR : ST_RESP;
            ST_WR:      state_nxt = ST_RESP;
            ST_RESP:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Request fields are captured once at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sign_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            sign_q  <= bus.req_signed;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    // Outputs are registered from the next state so they line up with the state cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            ram_ena       <= 1'b0;
            ram_wea       <= 1'b0;
            ram_addra     <= '0;
            ram_dina      <= '0;
            ram_addrb     <= '0;
        end else begin
            bus.req_ready <= (state_nxt == ST_IDLE);
            bus.rsp_valid <= (state_nxt == ST_RESP);
            ram_ena       <= (state_nxt == ST_WR);
            ram_wea       <= (state_nxt == ST_WR);

            if (accept) begin
                bus.rsp_rdata <= '0;
                bus.rsp_err   <= req_bad;
            end

            if (state_q == ST_IDLE && state_nxt == ST_RD_ADDR)
                ram_addrb <= bus.req_addr[BADDR_W-1:2];

            if (state_q == ST_RD_DATA && !we_q)
                bus.rsp_rdata <= DATA_W'(load_data);

            // Word stores take data straight from the bus; partial stores use the merged word.
            if (state_nxt == ST_WR) begin
                if (state_q == ST_IDLE) begin
                    ram_addra <= bus.req_addr[BADDR_W-1:2];
                    ram_dina  <= bus.req_wdata;
                end else begin
                    ram_addra <= addr_q[BADDR_W-1:2];
                    ram_dina  <= DATA_W'(merged);
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit with a behavioural 256x32 RAM.
module tb_dmem_access_unit;
    import dmem_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic mem_clr = 1'b1;

    dmem_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    logic        ram_ena, ram_wea;
    logic [7:0]  ram_addra, ram_addrb;
    logic [31:0] ram_dina, ram_doutb;
    logic [31:0] mem [256];

    int total = 0;
    int bad   = 0;

    dmem_access_unit #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ram_ena   (ram_ena),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_addrb (ram_addrb),
        .ram_doutb (ram_doutb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            ram_doutb <= '0;
        end else begin
            if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
            ram_doutb <= mem[ram_addrb];
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic        exp_wr;
        logic [7:0]  exp_waddr;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic sg,
                                input logic [9:0] a, input logic [31:0] wd,
                                input logic [31:0] er, input logic ee, input int lat,
                                input logic ew, input logic [7:0] wa, input logic [31:0] wdat);
        vec_t v;
        v.we = we; v.size = sz; v.sgn = sg; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat;
        v.exp_wr = ew; v.exp_waddr = wa; v.exp_wdata = wdat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.req_ready !== 1'b1) chk({tag, " ready timeout"}, 32'(bus.req_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   n, wr_n, lat;
        bit   got;
        logic [7:0]  wa;
        logic [31:0] wd;
        exp_t e;
        wait_ready(tag);
        bus.req_we     = v.we;
        bus.req_size   = v.size;
        bus.req_signed = v.sgn;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err, lat: v.exp_lat});
        // Scramble the bus after acceptance; the unit must use its latched copy.
        bus.req_valid  = 1'b0;
        bus.req_we     = ~v.we;
        bus.req_size   = ~v.size;
        bus.req_signed = ~v.sgn;
        bus.req_addr   = ~v.addr;
        bus.req_wdata  = ~v.wdata;
        wr_n = 0; got = 0; lat = 0; wa = '0; wd = '0;
        for (n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (ram_ena === 1'b1) begin
                wr_n++;
                wa = ram_addra;
                wd = ram_dina;
                chk({tag, " wea"}, 32'(ram_wea), 32'd1);
            end
            if (bus.rsp_valid === 1'b1) begin
                got = 1;
                lat = n;
                break;
            end
        end
        e = sb.pop_front();
        if (!got) begin
            chk({tag, " rsp timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, " rdata"}, bus.rsp_rdata, e.rdata);
            chk({tag, " err"}, 32'(bus.rsp_err), 32'(e.err));
            chk({tag, " latency"}, 32'(lat), 32'(e.lat));
            chk({tag, " writes"}, 32'(wr_n), v.exp_wr ? 32'd1 : 32'd0);
            if (v.exp_wr) begin
                chk({tag, " addra"}, 32'(wa), 32'(v.exp_waddr));
                chk({tag, " dina"}, wd, v.exp_wdata);
            end
            @(negedge clk);
            chk({tag, " pulse"}, 32'(bus.rsp_valid), 32'd0);
            chk({tag, " ready"}, 32'(bus.req_ready), 32'd1);
        end
    endtask

    initial begin
        int   n, seen;
        bit   got;
        vec_t v;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = SZ_BYTE;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

        // we sz sg addr wdata | rdata err lat | wr waddr wdata
        vecs.push_back(mk(1, SZ_WORD, 0, 10'h010, 32'hDEADBEEF, 32'h0,        0, 2, 1, 8'h04, 32'hDEADBEEF));
        vecs.push_back(mk(0, SZ_WORD, 0, 10'h010, 32'h0,        32'hDEADBEEF, 0, 3, 0, 8'h00, 32'h0));
        vecs.push_back(mk(1, SZ_BYTE, 0, 10'h012, 32'hFFFFFF55, 32'h0,        0, 4, 1, 8'h04, 32'hDE55BEEF));
        vecs.push_back(mk(0, SZ_BYTE, 1, 10'h013, 32'h0,        32'hFFFFFFDE, 0, 3, 0, 8'h00, 32'h0));
        vecs.push_back(mk(0, SZ_BYTE, 0, 10'h013, 32'h0,        32'h000000DE, 0, 3, 0, 8'h00, 32'h0));
        vecs.push_back(mk(0, SZ_BYTE, 1, 10'h011, 32'h0,        32'hFFFFFFBE, 0, 3, 0, 8'h00, 32'h0));
        vecs.push_back(mk(0, SZ_BYTE, 0, 10'h010, 32'h0,        32'h000000EF, 0, 3, 0, 8'h00, 32'h0));
        vecs.push_back(mk(1, SZ_HALF, 0, 10'h016, 32'h12348001, 32'h0,        0, 4, 1, 8'h05, 32'h80010000));
        vecs.push_back(mk(0, SZ_HALF, 1, 10'h016, 32'h0,        32'hFFFF8001, 0, 3, 0, 8'h00, 32'h0));
        vecs.push_back(mk(0, SZ_HALF, 0, 10'h016, 32'h0,        32'h00008001, 0, 3, 0, 8'h00, 32'h0));
        vecs.push_back(mk(0, SZ_HALF, 1, 10'h010, 32'h0,        32'hFFFFBEEF, 0, 3, 0, 8'h00, 32'h0));
        vecs.push_back(mk(0, SZ_HALF, 0, 10'h012, 32'h0,        32'h0000DE55, 0, 3, 0, 8'h00, 32'h0));
        vecs.push_back(mk(0, SZ_HALF, 0, 10'h011, 32'h0,        32'h0,        1, 1, 0, 8'h00, 32'h0));
        vecs.push_back(mk(1, SZ_WORD, 0, 10'h012, 32'h12345678, 32'h0,        1, 1, 0, 8'h00, 32'h0));
        vecs.push_back(mk(0, SZ_RSVD, 0, 10'h010, 32'h0,        32'h0,        1, 1, 0, 8'h00, 32'h0));
        vecs.push_back(mk(1, SZ_BYTE, 0, 10'h3FF, 32'h000000A5, 32'h0,        0, 4, 1, 8'hFF, 32'hA5000000));
        vecs.push_back(mk(0, SZ_WORD, 0, 10'h000, 32'h0,        32'h00000000, 0, 3, 0, 8'h00, 32'h0));
        vecs.push_back(mk(0, SZ_WORD, 1, 10'h3FC, 32'h0,        32'hA5000000, 0, 3, 0, 8'h00, 32'h0));
        vecs.push_back(mk(0, SZ_BYTE, 1, 10'h3FF, 32'h0,        32'hFFFFFFA5, 0, 3, 0, 8'h00, 32'h0));
        vecs.push_back(mk(1, SZ_HALF, 1, 10'h014, 32'h0000BEEF, 32'h0,        0, 4, 1, 8'h05, 32'h8001BEEF));
        vecs.push_back(mk(0, SZ_WORD, 0, 10'h014, 32'h0,        32'h8001BEEF, 0, 3, 0, 8'h00, 32'h0));

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst ena_wea", {30'd0, ram_ena, ram_wea}, 32'd0);
        chk("rst addra", 32'(ram_addra), 32'd0);
        chk("rst dina", ram_dina, 32'd0);
        chk("rst addrb", 32'(ram_addrb), 32'd0);
        rst_n = 1'b1;
        mem_clr = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset during the WR cycle of a byte store drops the write and the response
        wait_ready("midrst");
        bus.req_we = 1'b1; bus.req_size = SZ_BYTE; bus.req_signed = 1'b0;
        bus.req_addr = 10'h010; bus.req_wdata = 32'h00000077; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst ena in WR", 32'(ram_ena), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst ena drop", 32'(ram_ena), 32'd0);
        chk("midrst wea drop", 32'(ram_wea), 32'd0);
        chk("midrst ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) seen++;
        end
        chk("midrst no rsp", 32'(seen), 32'd0);
        chk("midrst ready after", 32'(bus.req_ready), 32'd1);
        v = mk(0, SZ_WORD, 0, 10'h010, 32'h0, 32'hDE55BEEF, 0, 3, 0, 8'h00, 32'h0);
        run_vec(v, "midrst reload");

        // req_valid held through RESP is only taken once back in IDLE
        wait_ready("hold");
        bus.req_we = 1'b0; bus.req_size = SZ_RSVD; bus.req_signed = 1'b0;
        bus.req_addr = 10'h010; bus.req_wdata = '0; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_size = SZ_WORD;
        @(negedge clk);
        chk("hold resp valid", 32'(bus.rsp_valid), 32'd1);
        chk("hold resp err", 32'(bus.rsp_err), 32'd1);
        chk("hold ready in RESP", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("hold idle valid", 32'(bus.rsp_valid), 32'd0);
        chk("hold idle ready", 32'(bus.req_ready), 32'd1);
        chk("hold err kept", 32'(bus.rsp_err), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        got = 0; n = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                got = 1;
                n = k;
                break;
            end
        end
        if (!got) chk("hold rsp timeout", 32'd0, 32'd1);
        else begin
            chk("hold latency", 32'(n), 32'd3);
            chk("hold rdata", bus.rsp_rdata, 32'hDE55BEEF);
            chk("hold err clear", 32'(bus.rsp_err), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
